// File: rtl/bcd_to_bin6_seq_pkg.sv
// Shared encodings and constants for the BCD <-> binary converter blocks.
package bcd_to_bin6_seq_pkg;

    // Converter FSM encoding, shared with the forward binary->BCD block.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reverse double dabble: a nibble >= BCD_THR after a right shift gets BCD_ADJ removed.
    localparam logic [3:0] BCD_ADJ = 4'd3;
    localparam logic [3:0] BCD_THR = 4'd8;

    // Decimal value of a two-digit BCD pair; 8 bits hold the worst case 15*10+15 = 165.
    function automatic logic [7:0] bcd_value(input logic [3:0] tens, input logic [3:0] ones);
        return 8'(tens) * 8'd10 + 8'(ones);
    endfunction

endpackage

// File: rtl/bcd_to_bin6_seq_nibble_sub3.sv
// Per-digit correction step of the reverse double dabble: d >= 8 ? d - 3 : d.
module bcd_nibble_sub3
    import bcd_to_bin6_seq_pkg::*;
(
    input  logic [3:0] i_d,
    output logic [3:0] o_d
);

    // Nibble is 8..15 when adjusted, so the subtraction never wraps.
    always_comb begin
        o_d = i_d;
        if (i_d >= BCD_THR) begin
            o_d = i_d - BCD_ADJ;
        end
    end

endmodule

// File: rtl/bcd_to_bin6_seq.sv
// Sequential two-digit BCD -> binary converter (shift right / subtract 3), one shift per clock.
module bcd_to_bin6_seq
    import bcd_to_bin6_seq_pkg::*;
#(
    parameter int unsigned BIN_W   = 6,
    parameter int unsigned MAX_VAL = 63
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [3:0]       i_tens,
    input  logic [3:0]       i_ones,
    output logic             o_busy,
    output logic             o_done,
    output logic [BIN_W-1:0] o_bin,
    output logic             o_err
);

    localparam int unsigned      Z_W       = 8 + BIN_W;
    localparam int unsigned      CNT_W     = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIN_W - 1);
    localparam logic [7:0]       MAX_VAL_B = 8'(MAX_VAL);

    state_t             r_state;
    state_t             w_state_d;
    logic [Z_W-1:0]     r_z;
    logic [Z_W-1:0]     w_z_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_d;
    logic               r_err_n;
    logic               w_err_n_d;
    logic [BIN_W-1:0]   r_bin;
    logic [BIN_W-1:0]   w_bin_d;
    logic               r_err;
    logic               w_err_d;

    logic [Z_W-1:0]     w_z_shift;
    logic [Z_W-1:0]     w_z_adj;
    logic [3:0]         w_tens_adj;
    logic [3:0]         w_ones_adj;
    logic               w_req_bad;

    // One datapath step: shift the work register, then correct both BCD digits.
    always_comb begin
        w_z_shift = r_z >> 1;
        w_z_adj   = {w_tens_adj, w_ones_adj, w_z_shift[BIN_W-1:0]};
    end

    bcd_nibble_sub3 u_sub3_tens (
        .i_d (w_z_shift[Z_W-1 -: 4]),
        .o_d (w_tens_adj)
    );

    bcd_nibble_sub3 u_sub3_ones (
        .i_d (w_z_shift[Z_W-5 -: 4]),
        .o_d (w_ones_adj)
    );

    // Request validity: both digits decimal and the value within range.
    always_comb begin
        w_req_bad = (i_tens > 4'd9) || (i_ones > 4'd9) || (bcd_value(i_tens, i_ones) > MAX_VAL_B);
    end

    // State register; async reset aborts any conversion in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and datapath next values; results are latched on the way into DONE.
    always_comb begin
        w_state_d = r_state;
        w_z_d     = r_z;
        w_cnt_d   = r_cnt;
        w_err_n_d = r_err_n;
        w_bin_d   = r_bin;
        w_err_d   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_z_d     = {i_tens, i_ones, {BIN_W{1'b0}}};
                    w_err_n_d = w_req_bad;
                    w_cnt_d   = '0;
                    w_state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                w_z_d   = w_z_adj;
                w_cnt_d = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    // Invalid requests still run the full conversion; only the result is masked.
                    w_bin_d   = r_err_n ? '0 : w_z_adj[BIN_W-1:0];
                    w_err_d   = r_err_n;
                    w_cnt_d   = '0;
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // Work register, shift counter, pending error and held results.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_z     <= '0;
            r_cnt   <= '0;
            r_err_n <= 1'b0;
            r_bin   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_z     <= w_z_d;
            r_cnt   <= w_cnt_d;
            r_err_n <= w_err_n_d;
            r_bin   <= w_bin_d;
            r_err   <= w_err_d;
        end
    end

    // Handshake and result outputs.
    always_comb begin
        o_busy = (r_state == ST_CONV) || (r_state == ST_DONE);
        o_done = (r_state == ST_DONE);
        o_bin  = r_bin;
        o_err  = r_err;
    end

endmodule

// File: tb/tb_bcd_to_bin6_seq.sv
// Self-checking bench for bcd_to_bin6_seq: arithmetic reference model plus directed literal checks.
module tb_bcd_to_bin6_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       busy;
    logic       done;
    logic [5:0] bin;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    bcd_to_bin6_seq #(
        .BIN_W   (6),
        .MAX_VAL (63)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_tens  (tens),
        .i_ones  (ones),
        .o_busy  (busy),
        .o_done  (done),
        .o_bin   (bin),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: decimal arithmetic and a cycle budget, not a shift datapath.
    // A request accepted at an edge keeps busy for 7 cycles; the last one is the done cycle.
    function automatic int dec_val(input logic [3:0] t, input logic [3:0] o);
        return int'(t) * 10 + int'(o);
    endfunction

    function automatic logic req_bad(input logic [3:0] t, input logic [3:0] o);
        return (t > 4'd9) || (o > 4'd9) || (dec_val(t, o) > 63);
    endfunction

    int         m_rem = 0;
    logic [5:0] m_bin_pend = '0;
    logic       m_err_pend = 1'b0;
    logic [5:0] m_bin = '0;
    logic       m_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem      <= 0;
            m_bin      <= '0;
            m_err      <= 1'b0;
            m_bin_pend <= '0;
            m_err_pend <= 1'b0;
        end else if (m_rem == 0) begin
            if (start) begin
                m_rem      <= 7;
                m_err_pend <= req_bad(tens, ones);
                m_bin_pend <= req_bad(tens, ones) ? 6'd0 : 6'(dec_val(tens, ones));
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin
                m_bin <= m_bin_pend;
                m_err <= m_err_pend;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_busy", int'(busy), int'(m_rem > 0));
            chk("model_done", int'(done), int'(m_rem == 1));
            chk("model_bin", int'(bin), int'(m_bin));
            chk("model_err", int'(err), int'(m_err));
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    // Issue one request, wait (bounded) for done and check latency and result literals.
    task automatic do_req(input string name, input logic [3:0] t, input logic [3:0] o,
                          input int exp_bin, input int exp_err);
        int n;
        @(negedge clk);
        start = 1'b1;
        tens  = t;
        ones  = o;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, 7);
        chk({name, "_bin"}, int'(bin), exp_bin);
        chk({name, "_err"}, int'(err), exp_err);
        @(negedge clk);
        chk({name, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        int base;
        int n;
        #1 rst = 1'b1;
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_bin", int'(bin), 0);
        chk("reset_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        do_req("max63", 4'd6, 4'd3, 63, 0);
        do_req("zero", 4'd0, 4'd0, 0, 0);
        do_req("v45", 4'd4, 4'd5, 45, 0);
        do_req("over64", 4'd6, 4'd4, 0, 1);
        do_req("digitA", 4'd2, 4'hA, 0, 1);
        do_req("v45b", 4'd4, 4'd5, 45, 0);

        // start pulsed while busy must be ignored
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        tens  = 4'd4;
        ones  = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        tens  = 4'd1;
        ones  = 4'd2;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_start_bin", int'(bin), 45);
        repeat (15) @(negedge clk);
        chk("busy_start_single_done", done_cnt - base, 1);

        // async reset in the middle of a conversion (bin still holds 45 here)
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        tens  = 4'd5;
        ones  = 4'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_bin", int'(bin), 0);
        chk("abort_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", done_cnt - base, 0);
        chk("abort_bin_held", int'(bin), 0);
        do_req("after_abort19", 4'd1, 4'd9, 19, 0);

        // sweep all 100 digit pairs back to back with start held high
        base = done_cnt;
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                tens = 4'(t);
                ones = 4'(o);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!done && n < 20);
                chk("sweep_gap", n, (t == 0 && o == 0) ? 7 : 8);
                chk("sweep_bin", int'(bin), (t * 10 + o <= 63) ? t * 10 + o : 0);
                chk("sweep_err", int'(err), (t * 10 + o > 63) ? 1 : 0);
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("sweep_done_count", done_cnt - base, 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

endmodule
